// File: rtl/user_lock_pkg.sv
// Shared types and constants for the user-locked register bank (read and write sides).
package user_lock_pkg;

  localparam int         DATA_W         = 8;
  localparam logic [1:0] DEFAULT_RD_USR = 2'h2;

  typedef enum logic [1:0] {
    RESP_OK       = 2'b00,
    RESP_DENIED   = 2'b01,
    RESP_BAD_ADDR = 2'b10
  } resp_err_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RESP   = 2'd1,
    LOCKED = 2'd2
  } rd_state_t;

  typedef struct packed {
    resp_err_t         err;
    logic [DATA_W-1:0] data;
  } resp_t;

  // Identity is checked before the address, so a foreign reader cannot
  // probe which indices exist. Data is scrubbed for every non-OK result.
  function automatic resp_t classify(input logic [1:0]        usr,
                                     input logic [1:0]        rd_usr,
                                     input logic              addr_ok,
                                     input logic [DATA_W-1:0] data);
    resp_t r;
    r.err  = RESP_OK;
    r.data = '0;
    if (usr != rd_usr)  r.err = RESP_DENIED;
    else if (!addr_ok)  r.err = RESP_BAD_ADDR;
    else                r.data = data;
    return r;
  endfunction

endpackage

// File: rtl/user_lock_guard.sv
// Denial counter and lockout timer. The counter saturates at the threshold;
// a lockout runs for LOCK_CYCLES cycles and clears the counter when it ends.
module user_lock_guard #(
  parameter int LOCK_THRESH = 3,
  parameter int LOCK_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic deny_i,     // a DENIED request was accepted
  input  logic grant_i,    // an OK request was accepted
  input  logic start_i,    // threshold response handed off: begin lockout
  output logic lock_hit_o, // counter sits at the threshold
  output logic locked_o,   // lockout in progress
  output logic expire_o    // last lockout cycle
);

  localparam int CW = $clog2(LOCK_THRESH + 1);
  localparam int TW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [CW-1:0] THRESH = CW'(LOCK_THRESH);
  localparam logic [TW-1:0] TLOAD  = TW'(LOCK_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          locked_q, locked_d;

  assign expire_o   = locked_q && (tmr_q == '0);
  assign lock_hit_o = (cnt_q == THRESH);
  assign locked_o   = locked_q;

  // Counter: cleared by a grant or by the end of a lockout, saturating on denials.
  always_comb begin
    cnt_d = cnt_q;
    if (expire_o || grant_i)          cnt_d = '0;
    else if (deny_i && !lock_hit_o)   cnt_d = cnt_q + CW'(1);
  end

  // Timer: loaded with LOCK_CYCLES-1 so locked stays high exactly LOCK_CYCLES cycles.
  always_comb begin
    tmr_d    = tmr_q;
    locked_d = locked_q;
    if (start_i) begin
      tmr_d    = TLOAD;
      locked_d = 1'b1;
    end else if (locked_q) begin
      if (tmr_q == '0) locked_d = 1'b0;
      else             tmr_d    = tmr_q - TW'(1);
    end
  end

  // Guard state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      tmr_q    <= '0;
      locked_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      tmr_q    <= tmr_d;
      locked_q <= locked_d;
    end
  end

endmodule

// File: rtl/user_locked_read_port.sv
// Read responder for the user-locked register bank: single outstanding request,
// data returned only to RD_USR, timed lockout after repeated denials.
module user_locked_read_port
  import user_lock_pkg::*;
#(
  parameter int         NUM_REGS    = 4,
  parameter int         ADDR_W      = 2,
  parameter logic [1:0] RD_USR      = DEFAULT_RD_USR,
  parameter int         LOCK_THRESH = 3,
  parameter int         LOCK_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [8*NUM_REGS-1:0]    regs_flat,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [1:0]               usr_id,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [7:0]               resp_data,
  output logic [1:0]               resp_err,
  output logic                     locked
);

  rd_state_t state_q, state_d;
  resp_t     resp_q, resp_d;
  resp_t     cap;
  logic [7:0] sel_data;
  logic       addr_ok;
  logic       accept, hs;
  logic       lock_hit, lock_expire, guard_locked;

  assign accept = req_valid && req_ready;
  assign hs     = resp_valid && resp_ready;

  // Register select; an index outside the bank leaves addr_ok low.
  always_comb begin
    sel_data = '0;
    addr_ok  = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (req_addr == ADDR_W'(i)) begin
        addr_ok  = 1'b1;
        sel_data = regs_flat[8*i +: 8];
      end
    end
  end

  assign cap = classify(usr_id, RD_USR, addr_ok, sel_data);

  user_lock_guard #(
    .LOCK_THRESH (LOCK_THRESH),
    .LOCK_CYCLES (LOCK_CYCLES)
  ) u_guard (
    .clk        (clk),
    .rst_n      (rst_n),
    .deny_i     (accept && (cap.err == RESP_DENIED)),
    .grant_i    (accept && (cap.err == RESP_OK)),
    .start_i    (hs && lock_hit),
    .lock_hit_o (lock_hit),
    .locked_o   (guard_locked),
    .expire_o   (lock_expire)
  );

  // Response capture: snapshot at accept, scrub once handed off.
  always_comb begin
    resp_d = resp_q;
    if (accept)  resp_d = cap;
    else if (hs) resp_d = '0;
  end

  // FSM state and capture registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      resp_q  <= resp_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)      state_d = RESP;
      RESP:    if (hs)          state_d = lock_hit ? LOCKED : IDLE;
      LOCKED:  if (lock_expire) state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  // Outputs decoded from registered state; data gated so nothing leaks
  // unless a valid OK response is being presented.
  always_comb begin
    req_ready  = rst_n && (state_q == IDLE);
    resp_valid = (state_q == RESP);
    locked     = guard_locked;
    resp_err   = resp_valid ? resp_q.err : RESP_OK;
    resp_data  = (resp_valid && (resp_q.err == RESP_OK)) ? resp_q.data : 8'h00;
  end

endmodule

// File: tb/tb_user_locked_read_port.sv
// Directed bench for user_locked_read_port (NUM_REGS=3 so a bad index exists).
module tb_user_locked_read_port;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] regs_flat;
  logic        req_valid, req_ready;
  logic [1:0]  req_addr, usr_id;
  logic        resp_valid, resp_ready;
  logic [7:0]  resp_data;
  logic [1:0]  resp_err;
  logic        locked;

  int n_chk  = 0;
  int n_fail = 0;
  logic leak_watch = 1'b0;
  logic leak_seen  = 1'b0;

  always #5 clk = ~clk;

  user_locked_read_port #(
    .NUM_REGS    (3),
    .ADDR_W      (2),
    .RD_USR      (2'h2),
    .LOCK_THRESH (3),
    .LOCK_CYCLES (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .regs_flat  (regs_flat),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .usr_id     (usr_id),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .locked     (locked)
  );

  // A5 must never show on resp_data while denied requests are in flight.
  always @(negedge clk) if (leak_watch && resp_data == 8'hA5) leak_seen = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one request at a negedge; returns at the negedge after acceptance.
  task automatic send(input logic [1:0] id, input logic [1:0] a);
    int n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    chk("req_ready_before_send", 32'(req_ready), 1);
    req_valid = 1'b1; usr_id = id; req_addr = a;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic handshake();
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic check_resp(input string tag, input logic [1:0] err, input logic [7:0] data);
    chk({tag, "_valid"}, 32'(resp_valid), 1);
    chk({tag, "_err"},   32'(resp_err),   32'(err));
    chk({tag, "_data"},  32'(resp_data),  32'(data));
  endtask

  initial begin
    int cnt;
    logic rdy_seen;
    rst_n = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    req_addr = '0; usr_id = '0;
    regs_flat = {8'h3C, 8'hA5, 8'h11};

    // Reset state
    @(negedge clk); @(negedge clk);
    chk("rst_req_ready",  32'(req_ready),  0);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_resp_data",  32'(resp_data),  0);
    chk("rst_resp_err",   32'(resp_err),   0);
    chk("rst_locked",     32'(locked),     0);
    rst_n = 1'b1;
    #1 chk("post_rst_req_ready", 32'(req_ready), 1);
    @(negedge clk);

    // Authorized read of reg1, response one cycle after accept
    send(2'd2, 2'd1);
    check_resp("auth", 2'b00, 8'hA5);
    chk("auth_req_ready_low", 32'(req_ready), 0);
    handshake();
    chk("auth_after_hs_valid", 32'(resp_valid), 0);
    chk("auth_after_hs_data",  32'(resp_data),  0);

    // Unauthorized read of the same register: scrubbed, held a few cycles
    leak_watch = 1'b1;
    send(2'd1, 2'd1);
    check_resp("deny1", 2'b01, 8'h00);
    repeat (3) @(negedge clk);
    check_resp("deny1_held", 2'b01, 8'h00);
    handshake();

    // Bad address from authorized user, then bad address from foreign user
    send(2'd2, 2'd3);
    check_resp("badaddr", 2'b10, 8'h00);
    handshake();
    send(2'd0, 2'd3);
    check_resp("deny_badaddr", 2'b01, 8'h00);
    handshake();
    // counter is 2 here only if BAD_ADDR left it alone
    chk("no_lock_after_2_denials", 32'(locked), 0);
    chk("idle_after_2_denials",    32'(req_ready), 1);

    // OK read clears the counter: two more denials must not lock
    send(2'd2, 2'd0);
    check_resp("auth_reg0", 2'b00, 8'h11);
    handshake();
    send(2'd1, 2'd0); handshake();
    send(2'd3, 2'd2); handshake();
    chk("ok_cleared_counter", 32'(locked), 0);

    // Third consecutive denial triggers a 16-cycle lockout
    send(2'd1, 2'd2);
    check_resp("deny3", 2'b01, 8'h00);
    handshake();
    cnt = 0; rdy_seen = 1'b0;
    while (locked && cnt < 40) begin
      cnt++;
      if (req_ready) rdy_seen = 1'b1;
      req_valid = 1'b1; usr_id = 2'd2; req_addr = 2'd1;
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("lockout_len",          32'(cnt), 16);
    chk("lockout_ready_low",    32'(rdy_seen), 0);
    chk("lockout_no_queue",     32'(resp_valid), 0);
    chk("lockout_exit_ready",   32'(req_ready), 1);
    leak_watch = 1'b0;
    chk("no_leak", 32'(leak_seen), 0);
    send(2'd2, 2'd2);
    check_resp("post_lock_auth", 2'b00, 8'h3C);
    handshake();

    // Backpressure: response frozen while regs change and requests arrive
    send(2'd2, 2'd1);
    for (int i = 0; i < 10; i++) begin
      regs_flat = {8'(i), 8'(8'h50 + i), 8'(i * 3)};
      req_valid = 1'b1; usr_id = 2'd2; req_addr = 2'd0;
      @(negedge clk);
      check_resp("bp", 2'b00, 8'hA5);
      chk("bp_ready_low", 32'(req_ready), 0);
    end
    req_valid = 1'b0;
    handshake();
    chk("bp_done_valid", 32'(resp_valid), 0);
    chk("bp_done_ready", 32'(req_ready), 1);
    regs_flat = {8'h3C, 8'hA5, 8'h11};

    // Reset in the middle of a lockout
    send(2'd0, 2'd0); handshake();
    send(2'd0, 2'd0); handshake();
    send(2'd0, 2'd0); handshake();
    repeat (5) @(negedge clk);
    chk("mid_lock_locked", 32'(locked), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_lock_locked",     32'(locked), 0);
    chk("rst_lock_resp_valid", 32'(resp_valid), 0);
    chk("rst_lock_req_ready",  32'(req_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_lock_release_ready", 32'(req_ready), 1);
    @(negedge clk);
    send(2'd1, 2'd0); handshake();
    send(2'd1, 2'd0); handshake();
    chk("rst_cleared_counter", 32'(locked), 0);
    send(2'd2, 2'd1);
    check_resp("final_auth", 2'b00, 8'hA5);
    handshake();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/user_locked_read_port.md
# user_locked_read_port

Read-side responder for the user-locked register bank. It accepts read requests over a valid/ready handshake and returns register contents only to the authorized reader ID. Unauthorized requests receive scrubbed data and an error code. Repeated denials trigger a timed lockout. It sits between the bus/debug read path and the bank of user-locked write registers, and consumes their flattened outputs.

## Interface
Parameters:
- NUM_REGS, 4, number of 8-bit registers exposed
- ADDR_W, 2, request address width
- RD_USR, 2'h2, only usr_id granted read access
- LOCK_THRESH, 3, consecutive denials that trigger lockout (≥1)
- LOCK_CYCLES, 16, lockout duration in clk cycles (≥1)

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- clk  input  1  sole clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- regs_flat  input  8*NUM_REGS  register values; reg i = bits [8i+7:8i]
- req_valid  input  1  read request valid
- req_ready  output  1  responder can accept a request
- req_addr  input  ADDR_W  register index
- usr_id  input  2  requester identity, sampled with the request
- resp_valid  output  1  response valid
- resp_ready  input  1  requester accepts response
- resp_data  output  8  read data; 8'h00 unless the status is OK
- resp_err  output  2  00 OK, 01 DENIED, 10 BAD_ADDR
- locked  output  1  high while in lockout

## Operation
- States:
  - IDLE: req_ready=1.
  - RESP: resp_valid=1; response held stable.
  - LOCKED: req_ready=0, locked=1.
- Accept: a request is accepted when req_valid && req_ready. At acceptance the block samples usr_id, req_addr and the addressed register, and moves to RESP.
- Classification, evaluated in priority order:
  1. usr_id != RD_USR → DENIED, data 8'h00.
  2. Otherwise, req_addr ≥ NUM_REGS → BAD_ADDR, data 8'h00.
  3. Otherwise → OK, data = the register value at the acceptance cycle.
- Denial counter (width $clog2(LOCK_THRESH+1)):
  - A DENIED response increments it.
  - An OK response clears it.
  - BAD_ADDR leaves it unchanged.
  - It saturates at LOCK_THRESH.
- RESP exit: leave RESP when resp_valid && resp_ready.
  - If the counter equals LOCK_THRESH, go to LOCKED and load the lockout timer with LOCK_CYCLES-1.
  - Otherwise go to IDLE.
- LOCKED:
  - The timer decrements every cycle.
  - On the cycle the timer reaches 0, the block returns to IDLE and clears the counter.
  - req_valid is ignored throughout LOCKED; requests are never queued.
- No data leakage: resp_data is 8'h00 whenever resp_valid=0 or resp_err != 00.
- regs_flat changes after acceptance do not alter a pending response.

## Timing
- Reset values: req_ready=0 during reset and 1 on the first cycle after deassertion. resp_valid=0, resp_data=8'h00, resp_err=2'b00, locked=0, counter=0, timer=0, state=IDLE.
- Latency: a request accepted on edge N gives resp_valid=1 after edge N (registered outputs). Minimum throughput is one request per 2 cycles.
- Backpressure: while resp_ready=0, resp_valid, resp_data and resp_err are held stable indefinitely.
- req_ready deasserts in the cycle after acceptance (combinational from state; no same-cycle re-accept).
- Lockout length: locked is high for exactly LOCK_CYCLES cycles. It starts the cycle after the handshake that completed the threshold-reaching DENIED response.
- Reset mid-response or mid-lockout: all state returns to reset values immediately. A pending response is dropped and the lockout is cancelled.

## Structure
- Shared package user_lock_pkg:
  - resp_err_t enum (RESP_OK, RESP_DENIED, RESP_BAD_ADDR)
  - rd_state_t enum (IDLE, RESP, LOCKED)
  - default RD_USR constant, shared with the write-side register
- Sub-module: user_lock_guard. It holds the denial counter and lockout timer, with inputs deny/grant/start. Its outputs are lock_hit and locked.
- The top level holds the FSM, the capture registers and the classification logic.

## Test plan
- Authorized read: regs_flat reg1=8'hA5, usr_id=2, addr=1.
  - Required: resp_valid one cycle after accept, data A5, err 00, counter 0.
- Unauthorized read: usr_id=1, addr=1.
  - Required: data 00, err 01, and A5 is never visible on resp_data.
- Bad address with NUM_REGS=3: usr_id=2, addr=3.
  - Required: err 10, data 00, counter unchanged.
  - Also: usr_id=0 with addr=3 → err 01.
- Lockout: three DENIED requests in a row.
  - Required: after the third handshake, locked=1 and req_ready=0 for exactly 16 cycles, and requests are ignored.
  - Then IDLE, and an authorized read succeeds.
- Backpressure: hold resp_ready=0 for 10 cycles while regs_flat changes.
  - Required: the response stays stable with the captured data, and no new request is accepted.
- Reset in LOCKED: assert rst_n=0 for 1 cycle mid-lockout.
  - Required: locked=0 and resp_valid=0 immediately; req_ready=1 after release; counter 0.
